// File: rtl/serial_add_sequencer.sv
// Multi-cycle add/subtract unit that time-shares one carry-lookahead slice across
// the byte positions of a WIDTH-bit operand, with a registered inter-slice carry.
module serial_add_sequencer #(
  parameter int WIDTH  = 32,
  parameter int SLICE  = 8,
  parameter int NSLICE = WIDTH / SLICE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_add,
  input  logic             ctrl_sub,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_carryOut,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One SLICE-wide carry-lookahead block: returns {carry_out, sum}.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = {(SLICE+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_cr;
  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic             w_start;
  logic [WIDTH-1:0] w_b_cond;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_slice;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;

  // Subtract wins when both start lines are high; B is inverted and Cin seeded with 1.
  assign w_start  = ctrl_add | ctrl_sub;
  assign w_b_cond = ctrl_sub ? ~data_operandB : data_operandB;

  // Select the operand byte pair addressed by the slice counter.
  always_comb begin
    w_a_sl = {SLICE{1'b0}};
    w_b_sl = {SLICE{1'b0}};
    for (int k = 0; k < NSLICE; k++) begin
      w_a_sl = (r_idx == IDXW'(k)) ? r_a_q[k*SLICE +: SLICE] : w_a_sl;
      w_b_sl = (r_idx == IDXW'(k)) ? r_b_q[k*SLICE +: SLICE] : w_b_sl;
    end
  end

  assign w_slice = cla_slice(w_a_sl, w_b_sl, r_cr);
  assign w_sum   = w_slice[SLICE-1:0];
  assign w_cout  = w_slice[SLICE];

  // Sequencer FSM with registered datapath state and outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= {IDXW{1'b0}};
      r_cr     <= 1'b0;
      r_a_q    <= {WIDTH{1'b0}};
      r_b_q    <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_rdy <= 1'b0;
          if (w_start) begin
            r_a_q   <= data_operandA;
            r_b_q   <= w_b_cond;
            r_cr    <= ctrl_sub;
            r_idx   <= {IDXW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IDXW'(k)) begin
              r_result[k*SLICE +: SLICE] <= w_sum;
            end
          end
          r_cr  <= w_cout;
          r_idx <= r_idx + 1'b1;
          // Overflow: like-signed operands producing a sum of the other sign.
          if (r_idx == LAST_IDX) begin
            r_carry <= w_cout;
            r_exc   <= (r_a_q[WIDTH-1] == r_b_q[WIDTH-1]) &
                       (w_sum[SLICE-1] != r_a_q[WIDTH-1]);
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_carryOut  = r_carry;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Multi-cycle 32-bit add/subtract unit that time-shares one 8-bit carry-lookahead slice across four byte positions. It latches operands on a start pulse, feeds one byte pair per cycle through the slice with a registered inter-slice carry, and assembles the result. It presents an overflow flag and a one-cycle ready pulse to the execute stage. It is the low-area alternative to the full-width adder for the ALU add/sub path.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 8, width of the shared carry-lookahead slice
- NSLICE, WIDTH/SLICE (4), slice passes per operation
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- ctrl_add  in  1  start pulse: A + B
- ctrl_sub  in  1  start pulse: A - B; priority over ctrl_add when both high
- data_operandA  in  WIDTH  operand A, sampled on the accepting edge only
- data_operandB  in  WIDTH  operand B, sampled on the accepting edge only
- data_result  out  WIDTH  sum/difference; valid while data_resultRDY=1
- data_carryOut  out  1  carry out of the MSB (sub: 1 = no borrow)
- data_exception  out  1  signed two's-complement overflow
- data_resultRDY  out  1  one-cycle pulse, result valid
- busy  out  1  high in RUN

## Operation
- States: IDLE, RUN, DONE. Counter idx (log2 NSLICE bits), carry register cr, latched regs a_q, b_q (b_q = ~B for sub, B for add).
- IDLE: a start (ctrl_add|ctrl_sub) on an edge latches A and the conditioned B, sets cr = ctrl_sub, idx = 0, and moves to RUN.
- RUN, each edge: the slice gets a_q[idx*SLICE +: SLICE], b_q[same], Cin = cr. S goes to data_result[idx*SLICE +: SLICE], cr <= Cout, idx <= idx+1.
- On the edge where idx = NSLICE-1: data_carryOut <= Cout and data_exception <= (a_q[MSB] == b_q[MSB]) & (S[SLICE-1] != a_q[MSB]). Then move to DONE.
- DONE: data_resultRDY = 1 for this cycle only. Next edge returns to IDLE, or goes to RUN if a start is present. Back-to-back starts are accepted in DONE.
- Start pulses in RUN are ignored. No queuing.
- ctrl_add and ctrl_sub both high: treated as subtract.
- data_result, data_carryOut, data_exception hold their values from the last completed operation until overwritten by the next operation's slice writes. Bytes in data_result are partially updated during RUN and valid only in DONE.
- Arithmetic is modulo 2^WIDTH. Carry and overflow are not sticky across operations.

## Timing
- Reset values: state IDLE, idx 0, cr 0, a_q/b_q 0, data_result 0, data_carryOut 0, data_exception 0, data_resultRDY 0, busy 0. Reset acts immediately without waiting for a clock edge.
- Latency: start sampled at edge E0. Slices are processed at E1..E4. data_resultRDY is high in the cycle between E4 and E5. Total NSLICE+1 cycles from start to ready.
- Throughput: one operation per NSLICE+1 cycles when started in DONE.
- busy is high from E0 through E4 (RUN cycles). It is low in IDLE and DONE.
- data_resultRDY comes from a registered state and is glitch-free.
- Reset mid-RUN aborts the operation. No ready pulse is produced. The next start after reset deasserts behaves as from power-up.
- Operand inputs may change freely after E0 without affecting the result.

## Test plan
- Cross-slice carry: add 0x000000FF + 0x00000001 -> data_result 0x00000100, carryOut 0, exception 0. Ready is high exactly 5 cycles after the start edge, for 1 cycle.
- Positive overflow: add 0x7FFFFFFF + 0x00000001 -> 0x80000000, exception 1, carryOut 0. Also add 0xFFFFFFFF + 0x00000001 -> 0x00000000, carryOut 1, exception 0.
- Subtract with borrow: sub 5 - 7 -> 0xFFFFFFFE, carryOut 0, exception 0. Negative overflow: sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, exception 1, carryOut 1.
- Handshake:
  - A ctrl_add pulse during RUN is ignored; the result matches the first operands.
  - A start held in the DONE cycle launches the next op with no IDLE cycle.
  - ctrl_add and ctrl_sub both high with A=10, B=3 -> result 7.
- Reset mid-operation: assert reset during the 3rd RUN cycle. All outputs go to 0 immediately and no ready pulse follows. After release, add 0x12345678 + 0x11111111 -> 0x23456789 with normal latency.
- Random regression: 10k random A/B/op against a behavioural reference for result, carryOut and exception. Check that busy and ready are never high together.
